// File: rtl/raisin64_mem_pkg.sv
// Shared constants for the Raisin64 memory path: access width encoding and the
// arbiter state encoding (also used by bus models).
package raisin64_mem_pkg;

    localparam logic [1:0] W_BYTE  = 2'b00;
    localparam logic [1:0] W_HALF  = 2'b01;
    localparam logic [1:0] W_WORD  = 2'b10;
    localparam logic [1:0] W_DWORD = 2'b11;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle   = 2'd0;
    localparam arb_state_t StIfetch = 2'd1;
    localparam arb_state_t StDread  = 2'd2;
    localparam arb_state_t StDwrite = 2'd3;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the load/store unit:
// one transaction at a time, round-robin on contention, optional ack timeout.
module mem_bus_arbiter
    import raisin64_mem_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [63:0] imem_addr,
    input  logic        imem_addr_valid,
    output logic [63:0] imem_data,
    output logic        imem_data_valid,

    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_dout,
    input  logic [1:0]  dmem_write_width,
    input  logic        dmem_rstrobe,
    input  logic        dmem_wstrobe,
    output logic [63:0] dmem_din,
    output logic        dmem_cycle_complete,

    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [1:0]  bus_width,
    output logic        bus_req,
    output logic        bus_we,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_error
);

    arb_state_t  state_q, state_d;
    logic        last_dmem_q, last_dmem_d;
    logic        dpend_q, dpend_d;
    logic [63:0] dreq_addr_q, dreq_addr_d;
    logic [63:0] dreq_data_q, dreq_data_d;
    logic [1:0]  dreq_width_q, dreq_width_d;
    logic        dreq_we_q, dreq_we_d;
    logic [63:0] fetch_tag_q, fetch_tag_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    logic [63:0] imem_data_q, imem_data_d;
    logic        imem_data_valid_q, imem_data_valid_d;
    logic [63:0] dmem_din_q, dmem_din_d;
    logic        dmem_cycle_complete_q, dmem_cycle_complete_d;
    logic [63:0] bus_addr_q, bus_addr_d;
    logic [63:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  bus_width_q, bus_width_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_error_q, bus_error_d;

    logic        timed_out;
    logic        done;
    logic [63:0] resp_data;
    logic        grant_dmem;
    logic        grant_imem;

    assign timed_out = (BUS_TIMEOUT != 0) && (tmo_cnt_q == BUS_TIMEOUT);
    assign done      = bus_ack || timed_out;
    // A timed-out transaction completes with zero read data.
    assign resp_data = bus_ack ? bus_rdata : '0;

    // Round-robin: on a tie the requester not served last wins.
    assign grant_dmem = dpend_q && (!imem_addr_valid || !last_dmem_q);
    assign grant_imem = imem_addr_valid && !grant_dmem;

    always_comb begin
        state_d               = state_q;
        last_dmem_d           = last_dmem_q;
        dpend_d               = dpend_q;
        dreq_addr_d           = dreq_addr_q;
        dreq_data_d           = dreq_data_q;
        dreq_width_d          = dreq_width_q;
        dreq_we_d             = dreq_we_q;
        fetch_tag_d           = fetch_tag_q;
        tmo_cnt_d             = tmo_cnt_q;
        imem_data_d           = imem_data_q;
        imem_data_valid_d     = 1'b0;
        dmem_din_d            = dmem_din_q;
        dmem_cycle_complete_d = 1'b0;
        bus_addr_d            = bus_addr_q;
        bus_wdata_d           = bus_wdata_q;
        bus_width_d           = bus_width_q;
        bus_req_d             = bus_req_q;
        bus_we_d              = bus_we_q;
        bus_error_d           = bus_error_q;

        // Strobes are one-cycle pulses; capture them unless a request is already owned.
        if (!dpend_q && (dmem_rstrobe || dmem_wstrobe)) begin
            dpend_d      = 1'b1;
            dreq_addr_d  = dmem_addr;
            dreq_data_d  = dmem_dout;
            dreq_width_d = dmem_write_width;
            dreq_we_d    = dmem_wstrobe;
        end

        unique case (state_q)
            StIdle: begin
                if (grant_dmem) begin
                    state_d     = dreq_we_q ? StDwrite : StDread;
                    bus_addr_d  = dreq_addr_q;
                    bus_wdata_d = dreq_data_q;
                    bus_width_d = dreq_width_q;
                    bus_we_d    = dreq_we_q;
                    bus_req_d   = 1'b1;
                    last_dmem_d = 1'b1;
                    tmo_cnt_d   = '0;
                end else if (grant_imem) begin
                    state_d     = StIfetch;
                    bus_addr_d  = imem_addr;
                    bus_wdata_d = '0;
                    bus_width_d = W_DWORD;
                    bus_we_d    = 1'b0;
                    bus_req_d   = 1'b1;
                    last_dmem_d = 1'b0;
                    fetch_tag_d = imem_addr;
                    tmo_cnt_d   = '0;
                end
            end
            StIfetch: begin
                if (done) begin
                    imem_data_d = resp_data;
                    // Drop the response if the core jumped away while it was in flight.
                    imem_data_valid_d = imem_addr_valid && (imem_addr == fetch_tag_q);
                end
            end
            StDread: begin
                if (done) begin
                    dmem_din_d            = resp_data;
                    dmem_cycle_complete_d = 1'b1;
                    dpend_d               = 1'b0;
                end
            end
            StDwrite: begin
                if (done) begin
                    dmem_cycle_complete_d = 1'b1;
                    dpend_d               = 1'b0;
                end
            end
        endcase

        if (state_q != StIdle) begin
            if (done) begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
                tmo_cnt_d = '0;
                if (timed_out && !bus_ack) begin
                    bus_error_d = 1'b1;
                end
            end else if (BUS_TIMEOUT != 0) begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= StIdle;
            last_dmem_q           <= 1'b0;
            dpend_q               <= 1'b0;
            dreq_addr_q           <= '0;
            dreq_data_q           <= '0;
            dreq_width_q          <= '0;
            dreq_we_q             <= 1'b0;
            fetch_tag_q           <= '0;
            tmo_cnt_q             <= '0;
            imem_data_q           <= '0;
            imem_data_valid_q     <= 1'b0;
            dmem_din_q            <= '0;
            dmem_cycle_complete_q <= 1'b0;
            bus_addr_q            <= '0;
            bus_wdata_q           <= '0;
            bus_width_q           <= '0;
            bus_req_q             <= 1'b0;
            bus_we_q              <= 1'b0;
            bus_error_q           <= 1'b0;
        end else begin
            state_q               <= state_d;
            last_dmem_q           <= last_dmem_d;
            dpend_q               <= dpend_d;
            dreq_addr_q           <= dreq_addr_d;
            dreq_data_q           <= dreq_data_d;
            dreq_width_q          <= dreq_width_d;
            dreq_we_q             <= dreq_we_d;
            fetch_tag_q           <= fetch_tag_d;
            tmo_cnt_q             <= tmo_cnt_d;
            imem_data_q           <= imem_data_d;
            imem_data_valid_q     <= imem_data_valid_d;
            dmem_din_q            <= dmem_din_d;
            dmem_cycle_complete_q <= dmem_cycle_complete_d;
            bus_addr_q            <= bus_addr_d;
            bus_wdata_q           <= bus_wdata_d;
            bus_width_q           <= bus_width_d;
            bus_req_q             <= bus_req_d;
            bus_we_q              <= bus_we_d;
            bus_error_q           <= bus_error_d;
        end
    end

    assign imem_data           = imem_data_q;
    assign imem_data_valid     = imem_data_valid_q;
    assign dmem_din            = dmem_din_q;
    assign dmem_cycle_complete = dmem_cycle_complete_q;
    assign bus_addr            = bus_addr_q;
    assign bus_wdata           = bus_wdata_q;
    assign bus_width           = bus_width_q;
    assign bus_req             = bus_req_q;
    assign bus_we              = bus_we_q;
    assign bus_error           = bus_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a simple memory/request model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic [63:0] imem_data;
    logic        imem_data_valid;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_dout;
    logic [1:0]  dmem_write_width;
    logic        dmem_rstrobe;
    logic        dmem_wstrobe;
    logic [63:0] dmem_din;
    logic        dmem_cycle_complete;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [1:0]  bus_width;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_rdata;
    logic        bus_ack;
    logic        bus_error;

    logic        man_ack;
    logic [63:0] man_rdata;
    logic        auto_ack;
    logic [63:0] auto_rdata;
    bit          resp_en;
    int          max_delay;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] bus_mem [logic [63:0]];
    logic [63:0] sw_mem  [logic [63:0]];

    assign bus_ack   = resp_en ? auto_ack : man_ack;
    assign bus_rdata = resp_en ? auto_rdata : man_rdata;

    mem_bus_arbiter #(.BUS_TIMEOUT(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .imem_addr           (imem_addr),
        .imem_addr_valid     (imem_addr_valid),
        .imem_data           (imem_data),
        .imem_data_valid     (imem_data_valid),
        .dmem_addr           (dmem_addr),
        .dmem_dout           (dmem_dout),
        .dmem_write_width    (dmem_write_width),
        .dmem_rstrobe        (dmem_rstrobe),
        .dmem_wstrobe        (dmem_wstrobe),
        .dmem_din            (dmem_din),
        .dmem_cycle_complete (dmem_cycle_complete),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_width           (bus_width),
        .bus_req             (bus_req),
        .bus_we              (bus_we),
        .bus_rdata           (bus_rdata),
        .bus_ack             (bus_ack),
        .bus_error           (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] fdata(input logic [63:0] a);
        return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    // Bus-side memory model: acks after a random delay when enabled.
    initial begin
        int wait_cnt;
        int cur_delay;
        wait_cnt   = 0;
        cur_delay  = 0;
        auto_ack   = 1'b0;
        auto_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            auto_ack = 1'b0;
            if (resp_en && bus_req) begin
                if (wait_cnt >= cur_delay) begin
                    auto_ack = 1'b1;
                    if (bus_we) begin
                        bus_mem[bus_addr] = bus_wdata;
                        auto_rdata = '0;
                    end else begin
                        auto_rdata = bus_mem.exists(bus_addr) ? bus_mem[bus_addr] : fdata(bus_addr);
                    end
                    wait_cnt  = 0;
                    cur_delay = int'($urandom_range(0, max_delay));
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        imem_addr        = '0;
        imem_addr_valid  = 1'b0;
        dmem_addr        = '0;
        dmem_dout        = '0;
        dmem_write_width = '0;
        dmem_rstrobe     = 1'b0;
        dmem_wstrobe     = 1'b0;
        man_ack          = 1'b0;
        man_rdata        = '0;
        resp_en          = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus_req, bus_we, bus_error, imem_data_valid, dmem_cycle_complete} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: req=%b we=%b err=%b iv=%b dc=%b, want all 0",
                     bus_req, bus_we, bus_error, imem_data_valid, dmem_cycle_complete);
        end
        n_checks++;
        if (bus_addr !== 64'h0 || bus_wdata !== 64'h0 || bus_width !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h width=%b, want 0", bus_addr, bus_wdata,
                     bus_width);
        end
        n_checks++;
        if (imem_data !== 64'h0 || dmem_din !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_data: imem_data=%h dmem_din=%h, want 0", imem_data, dmem_din);
        end
    endtask

    task automatic test_single_fetch();
        int pulses;
        do_reset();
        imem_addr = 64'h1000;
        imem_addr_valid = 1'b1;
        step();
        n_checks++;
        if (bus_req !== 1'b1 || bus_addr !== 64'h1000 || bus_width !== 2'b11 || bus_we !== 1'b0)
        begin
            n_errors++;
            $display("FAIL fetch_issue: req=%b addr=%h width=%b we=%b, want 1 1000 11 0",
                     bus_req, bus_addr, bus_width, bus_we);
        end
        pulses = 0;
        step();
        if (imem_data_valid) pulses++;
        step();
        if (imem_data_valid) pulses++;
        man_rdata = 64'hDEADBEEF;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (imem_data_valid !== 1'b1 || imem_data !== 64'hDEADBEEF || bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_resp: valid=%b data=%h req=%b, want 1 deadbeef 0",
                     imem_data_valid, imem_data, bus_req);
        end
        if (imem_data_valid) pulses++;
        imem_addr_valid = 1'b0;
        step();
        if (imem_data_valid) pulses++;
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL fetch_pulse_count: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_store_during_fetch();
        do_reset();
        imem_addr = 64'h1000;
        imem_addr_valid = 1'b1;
        step();
        dmem_wstrobe = 1'b1;
        dmem_addr = 64'h2008;
        dmem_dout = 64'h55;
        dmem_write_width = 2'b00;
        step();
        dmem_wstrobe = 1'b0;
        dmem_addr = 64'hFFFF;
        dmem_dout = 64'hAA;
        man_rdata = 64'h77;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (imem_data_valid !== 1'b1 || imem_data !== 64'h77 || bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL store_fetch_first: valid=%b data=%h req=%b, want 1 77 0",
                     imem_data_valid, imem_data, bus_req);
        end
        imem_addr_valid = 1'b0;
        step();
        n_checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 64'h2008 ||
            bus_wdata !== 64'h55 || bus_width !== 2'b00) begin
            n_errors++;
            $display("FAIL store_issue: req=%b we=%b addr=%h wdata=%h width=%b, want 1 1 2008 55 00",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_width);
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (dmem_cycle_complete !== 1'b1 || bus_req !== 1'b0 || dmem_din !== 64'h0) begin
            n_errors++;
            $display("FAIL store_complete: dc=%b req=%b din=%h, want 1 0 0",
                     dmem_cycle_complete, bus_req, dmem_din);
        end
        step();
        n_checks++;
        if (dmem_cycle_complete !== 1'b0 || bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL store_once: dc=%b req=%b, want 0 0", dmem_cycle_complete, bus_req);
        end
    endtask

    // Grant order encoded as decimal digits: 1 = dmem, 2 = imem.
    task automatic test_contention();
        int  seq;
        int  n;
        int  loads;
        bit  prev_req;
        bit  raise_valid;
        do_reset();
        resp_en = 1'b1;
        max_delay = 0;
        seq = 0; n = 0; loads = 1; prev_req = 0;
        dmem_rstrobe = 1'b1;
        dmem_addr = 64'h3000;
        for (int c = 1; c < 14; c++) begin
            step();
            if (bus_req && !prev_req && n < 4) begin
                seq = seq * 10 + (bus_addr == 64'h3000 ? 1 : 2);
                n++;
            end
            prev_req = bus_req;
            dmem_rstrobe = 1'b0;
            if (c == 1) begin
                imem_addr = 64'h1000;
                imem_addr_valid = 1'b1;
            end
            if (dmem_cycle_complete && loads < 2) begin
                dmem_rstrobe = 1'b1;
                loads++;
            end
        end
        n_checks++;
        if (seq != 1212) begin
            n_errors++;
            $display("FAIL contention_alt: grants=%0d, want 1212", seq);
        end

        do_reset();
        resp_en = 1'b1;
        max_delay = 0;
        seq = 0; n = 0; loads = 1; prev_req = 0; raise_valid = 0;
        dmem_rstrobe = 1'b1;
        dmem_addr = 64'h3000;
        for (int c = 1; c < 14; c++) begin
            step();
            if (bus_req && !prev_req && n < 3) begin
                seq = seq * 10 + (bus_addr == 64'h3000 ? 1 : 2);
                n++;
            end
            prev_req = bus_req;
            dmem_rstrobe = 1'b0;
            if (raise_valid) begin
                imem_addr = 64'h1000;
                imem_addr_valid = 1'b1;
                raise_valid = 0;
            end
            if (dmem_cycle_complete && loads < 2) begin
                dmem_rstrobe = 1'b1;
                raise_valid = 1;
                loads++;
            end
        end
        n_checks++;
        if (seq != 121) begin
            n_errors++;
            $display("FAIL contention_imem_tie: grants=%0d, want 121", seq);
        end
        resp_en = 1'b0;
        imem_addr_valid = 1'b0;
    endtask

    task automatic test_jump_cancel();
        do_reset();
        imem_addr = 64'h1000;
        imem_addr_valid = 1'b1;
        step();
        step();
        imem_addr = 64'h4000;
        step();
        man_rdata = 64'h1111;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (imem_data_valid !== 1'b0 || bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL jump_stale: valid=%b req=%b, want 0 0", imem_data_valid, bus_req);
        end
        step();
        n_checks++;
        if (bus_req !== 1'b1 || bus_addr !== 64'h4000) begin
            n_errors++;
            $display("FAIL jump_refetch: req=%b addr=%h, want 1 4000", bus_req, bus_addr);
        end
        man_rdata = 64'h2222;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (imem_data_valid !== 1'b1 || imem_data !== 64'h2222) begin
            n_errors++;
            $display("FAIL jump_resp: valid=%b data=%h, want 1 2222", imem_data_valid, imem_data);
        end
        imem_addr_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        dmem_rstrobe = 1'b1;
        dmem_addr = 64'h5000;
        step();
        dmem_rstrobe = 1'b0;
        step();
        man_rdata = 64'hCAFE;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_checks++;
        if (dmem_cycle_complete !== 1'b1 || dmem_din !== 64'hCAFE || bus_error !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_preload: dc=%b din=%h err=%b, want 1 cafe 0",
                     dmem_cycle_complete, dmem_din, bus_error);
        end
        dmem_rstrobe = 1'b1;
        dmem_addr = 64'h5008;
        step();
        dmem_rstrobe = 1'b0;
        k = 0;
        while (!bus_req && k < 5) begin
            step();
            k++;
        end
        n_checks++;
        if (!bus_req) begin
            n_errors++;
            $display("FAIL timeout_grant: req=%b after %0d cycles, want 1", bus_req, k);
        end
        k = 0;
        while (!dmem_cycle_complete && k < 20) begin
            if (bus_error) break;
            step();
            k++;
        end
        n_checks++;
        if (k != 9 || dmem_cycle_complete !== 1'b1 || dmem_din !== 64'h0 || bus_error !== 1'b1)
        begin
            n_errors++;
            $display("FAIL timeout_resp: cycles=%0d dc=%b din=%h err=%b, want 9 1 0 1",
                     k, dmem_cycle_complete, dmem_din, bus_error);
        end
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (bus_error !== 1'b1 || bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_sticky: err=%b req=%b, want 1 0", bus_error, bus_req);
        end
        do_reset();
        n_checks++;
        if (bus_error !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_clear: err=%b, want 0", bus_error);
        end
    endtask

    task automatic test_reset_mid_write();
        int pulses;
        do_reset();
        dmem_wstrobe = 1'b1;
        dmem_addr = 64'h6000;
        dmem_dout = 64'h99;
        dmem_write_width = 2'b10;
        step();
        dmem_wstrobe = 1'b0;
        step();
        n_checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1) begin
            n_errors++;
            $display("FAIL rstw_issue: req=%b we=%b, want 1 1", bus_req, bus_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || bus_we !== 1'b0) begin
            n_errors++;
            $display("FAIL rstw_async: req=%b we=%b, want 0 0", bus_req, bus_we);
        end
        step();
        step();
        rst_n = 1'b1;
        man_ack = 1'b1;
        pulses = 0;
        step();
        man_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dmem_cycle_complete || bus_req) pulses++;
            step();
        end
        n_checks++;
        if (pulses != 0 || dmem_din !== 64'h0 || bus_error !== 1'b0) begin
            n_errors++;
            $display("FAIL rstw_quiet: activity=%0d din=%h err=%b, want 0 0 0",
                     pulses, dmem_din, bus_error);
        end
    endtask

    task automatic test_random();
        bit          d_out;
        bit          d_store;
        logic [63:0] d_addr;
        logic [63:0] d_data;
        logic [1:0]  d_width;
        logic [63:0] d_exp;
        int          d_age;
        int          i_age;
        bit          prev_req;
        bit          issue;
        int          kind;
        do_reset();
        bus_mem.delete();
        sw_mem.delete();
        max_delay = 3;
        resp_en = 1'b1;
        d_out = 0; d_store = 0; d_addr = '0; d_data = '0; d_width = '0; d_exp = '0;
        d_age = 0; i_age = 0; prev_req = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            step();
            issue = (cyc < 800);
            if (bus_req && !prev_req) begin
                n_checks++;
                if (bus_addr >= 64'h1_0000_0000) begin
                    if (bus_we !== 1'b0 || bus_width !== 2'b11) begin
                        n_errors++;
                        $display("FAIL rnd_fetch_grant: we=%b width=%b, want 0 11", bus_we,
                                 bus_width);
                    end
                end else if (!d_out || bus_we !== d_store || bus_addr !== d_addr ||
                             bus_width !== d_width || (d_store && bus_wdata !== d_data)) begin
                    n_errors++;
                    $display("FAIL rnd_dmem_grant: we=%b addr=%h width=%b wdata=%h, want %b %h %b %h",
                             bus_we, bus_addr, bus_width, bus_wdata, d_store, d_addr, d_width,
                             d_data);
                end
            end
            prev_req = bus_req;
            if (dmem_cycle_complete) begin
                n_checks++;
                if (!d_out) begin
                    n_errors++;
                    $display("FAIL rnd_spurious_complete: dc=1, want 0");
                end else if (!d_store && dmem_din !== d_exp) begin
                    n_errors++;
                    $display("FAIL rnd_load: din=%h, want %h (addr %h)", dmem_din, d_exp, d_addr);
                end
                d_out = 0;
                d_age = 0;
            end else if (d_out) begin
                d_age++;
                if (d_age > 60) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rnd_dmem_stall: no complete after %0d cycles, want <=60", d_age);
                    d_out = 0;
                end
            end
            if (imem_data_valid) begin
                n_checks++;
                if (!imem_addr_valid || imem_data !== fdata(imem_addr)) begin
                    n_errors++;
                    $display("FAIL rnd_fetch: valid_in=%b data=%h, want 1 %h", imem_addr_valid,
                             imem_data, fdata(imem_addr));
                end
                imem_addr = imem_addr + 64'd8;
                i_age = 0;
            end else if (imem_addr_valid) begin
                i_age++;
                if (i_age > 80) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rnd_fetch_stall: no response after %0d cycles, want <=80",
                             i_age);
                    i_age = 0;
                end
            end

            dmem_rstrobe = 1'b0;
            dmem_wstrobe = 1'b0;
            if (issue && !d_out && $urandom_range(0, 3) == 0) begin
                kind             = int'($urandom_range(0, 2));
                d_addr           = 64'h2000 + 64'($urandom_range(0, 7)) * 64'd8;
                d_data           = {$urandom, $urandom};
                d_width          = 2'($urandom_range(0, 3));
                d_store          = (kind != 0);
                dmem_addr        = d_addr;
                dmem_dout        = d_data;
                dmem_write_width = d_width;
                dmem_rstrobe     = (kind != 1);
                dmem_wstrobe     = (kind != 0);
                if (d_store) begin
                    sw_mem[d_addr] = d_data;
                end else begin
                    d_exp = sw_mem.exists(d_addr) ? sw_mem[d_addr] : fdata(d_addr);
                end
                d_out = 1;
                d_age = 0;
            end else if (issue && d_out && $urandom_range(0, 7) == 0) begin
                // Strobe while a request is owned; must be ignored.
                dmem_addr    = 64'h9000;
                dmem_dout    = {$urandom, $urandom};
                dmem_wstrobe = 1'b1;
            end

            if (!issue) begin
                imem_addr_valid = 1'b0;
            end else if (!imem_addr_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    imem_addr_valid = 1'b1;
                    imem_addr = 64'h1_0000_0000 + 64'($urandom_range(0, 255)) * 64'd8;
                    i_age = 0;
                end
            end else begin
                kind = int'($urandom_range(0, 31));
                if (kind < 2) begin
                    imem_addr = 64'h1_0000_0000 + 64'($urandom_range(0, 255)) * 64'd8;
                    i_age = 0;
                end else if (kind == 2) begin
                    imem_addr_valid = 1'b0;
                end
            end
        end
        n_checks++;
        if (d_out || bus_req !== 1'b0 || bus_error !== 1'b0) begin
            n_errors++;
            $display("FAIL rnd_drain: outstanding=%b req=%b err=%b, want 0 0 0", d_out, bus_req,
                     bus_error);
        end
        resp_en = 1'b0;
    endtask

    initial begin
        resp_en = 1'b0;
        max_delay = 3;
        test_reset();
        test_single_fetch();
        test_store_during_fetch();
        test_contention();
        test_jump_cancel();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
